// File: rtl/flash_upd_pkg.sv
// Shared sizing constants and drain-FSM encoding for the flash update path
// (UART byte collection -> page buffer -> flash page programming).
package flash_upd_pkg;

    localparam int PAGE_BYTES = 256;
    localparam int PAGE_AW    = 8;
    localparam int SIZE_W     = 24;

    localparam int PAGE_CNT_W = SIZE_W - PAGE_AW + 1;
    localparam int RAM_AW     = PAGE_AW + 1;
    localparam int RAM_DEPTH  = 2 * PAGE_BYTES;

    localparam logic [PAGE_AW:0] PAGE_LEN_MAX = (PAGE_AW + 1)'(PAGE_BYTES);

    typedef enum logic [2:0] {
        D_IDLE   = 3'd0,
        D_LOAD   = 3'd1,
        D_OFFER  = 3'd2,
        D_STREAM = 3'd3,
        D_DONE   = 3'd4
    } drain_state_e;

endpackage

// File: rtl/page_dpram.sv
// Simple dual-port byte RAM holding both page banks: one write port and one
// read port whose output register holds its value while no read is issued.
module page_dpram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    // NOTE: the storage array is deliberately not reset so it maps onto block RAM;
    // only the read register gets a reset value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/flash_page_buffer.sv
// Ping-pong page buffer: fills one 256-byte bank from the UART byte stream while
// the other bank is streamed byte-by-byte into the flash page writer.
module flash_page_buffer
    import flash_upd_pkg::*;
(
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  prog_start_i,
    input  logic [SIZE_W-1:0]     prog_size_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    input  logic                  flash_wr_ready_i,
    output logic                  flash_wr_en_o,
    output logic [7:0]            flash_wr_data_o,
    input  logic                  flash_wr_req_i,
    output logic                  flash_wr_done_o,
    output logic [PAGE_CNT_W-1:0] page_cnt_o,
    output logic                  prog_done_o,
    output logic                  overflow_err_o
);

    drain_state_e state_q, state_d;

    logic                       session_q,    session_d;
    logic [SIZE_W-1:0]          size_q,       size_d;
    logic [1:0]                 full_q,       full_d;
    logic [1:0][PAGE_AW:0]      len_q,        len_d;
    logic                       fill_bank_q,  fill_bank_d;
    logic [PAGE_AW:0]           fill_ptr_q,   fill_ptr_d;
    logic [SIZE_W-1:0]          rx_total_q,   rx_total_d;
    logic                       err_q,        err_d;
    logic                       drain_bank_q, drain_bank_d;
    logic [PAGE_AW:0]           drain_ptr_q,  drain_ptr_d;
    logic [SIZE_W-1:0]          drained_q,    drained_d;
    logic [PAGE_CNT_W-1:0]      page_cnt_q,   page_cnt_d;
    logic                       wr_en_q,      wr_en_d;
    logic                       done_q,       done_d;

    logic                       accept;
    logic [PAGE_AW:0]           fill_ptr_inc;
    logic [SIZE_W-1:0]          rx_total_inc;
    logic                       fill_close;
    logic [PAGE_AW:0]           drain_ptr_inc;
    logic [SIZE_W-1:0]          drained_inc;
    logic                       last_byte;
    logic                       take_page;
    logic                       consume;

    logic                       ram_re;
    logic [RAM_AW-1:0]          ram_raddr;
    logic [7:0]                 ram_rdata;

    assign accept        = byte_valid_i && byte_ready_o && !prog_start_i;
    assign fill_ptr_inc  = fill_ptr_q + (PAGE_AW + 1)'(1);
    assign rx_total_inc  = rx_total_q + SIZE_W'(1);
    assign fill_close    = (fill_ptr_inc == PAGE_LEN_MAX) || (rx_total_inc == size_q);
    assign drain_ptr_inc = drain_ptr_q + (PAGE_AW + 1)'(1);
    assign drained_inc   = drained_q + SIZE_W'(1);
    assign last_byte     = (drain_ptr_inc == len_q[drain_bank_q]);
    assign take_page     = (state_q == D_OFFER) && flash_wr_ready_i && !prog_start_i;
    assign consume       = (state_q == D_STREAM) && flash_wr_req_i && !prog_start_i;

    page_dpram #(
        .DEPTH (RAM_DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .we    (accept),
        .waddr ({fill_bank_q, fill_ptr_q[PAGE_AW-1:0]}),
        .wdata (byte_data_i),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= D_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (prog_start_i) begin
            state_d = (prog_size_i == '0) ? D_DONE : D_IDLE;
        end else begin
            case (state_q)
                D_IDLE:   if (full_q[drain_bank_q]) state_d = D_LOAD;
                D_LOAD:   state_d = D_OFFER;
                D_OFFER:  if (flash_wr_ready_i) state_d = D_STREAM;
                D_STREAM: if (consume && last_byte) begin
                              state_d = (drained_inc == size_q) ? D_DONE : D_IDLE;
                          end
                D_DONE:   state_d = D_DONE;
                default:  state_d = D_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            session_q    <= 1'b0;
            size_q       <= '0;
            full_q       <= '0;
            len_q        <= '0;
            fill_bank_q  <= 1'b0;
            fill_ptr_q   <= '0;
            rx_total_q   <= '0;
            err_q        <= 1'b0;
            drain_bank_q <= 1'b0;
            drain_ptr_q  <= '0;
            drained_q    <= '0;
            page_cnt_q   <= '0;
            wr_en_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            session_q    <= session_d;
            size_q       <= size_d;
            full_q       <= full_d;
            len_q        <= len_d;
            fill_bank_q  <= fill_bank_d;
            fill_ptr_q   <= fill_ptr_d;
            rx_total_q   <= rx_total_d;
            err_q        <= err_d;
            drain_bank_q <= drain_bank_d;
            drain_ptr_q  <= drain_ptr_d;
            drained_q    <= drained_d;
            page_cnt_q   <= page_cnt_d;
            wr_en_q      <= wr_en_d;
            done_q       <= done_d;
        end
    end

    // NOTE: every signal gets a default at the top of the block so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        session_d    = session_q;
        size_d       = size_q;
        full_d       = full_q;
        len_d        = len_q;
        fill_bank_d  = fill_bank_q;
        fill_ptr_d   = fill_ptr_q;
        rx_total_d   = rx_total_q;
        err_d        = err_q;
        drain_bank_d = drain_bank_q;
        drain_ptr_d  = drain_ptr_q;
        drained_d    = drained_q;
        page_cnt_d   = page_cnt_q;
        wr_en_d      = 1'b0;
        done_d       = 1'b0;

        if (prog_start_i) begin
            session_d    = 1'b1;
            size_d       = prog_size_i;
            full_d       = '0;
            len_d        = '0;
            fill_bank_d  = 1'b0;
            fill_ptr_d   = '0;
            rx_total_d   = '0;
            err_d        = 1'b0;
            drain_bank_d = 1'b0;
            drain_ptr_d  = '0;
            drained_d    = '0;
            page_cnt_d   = '0;
        end else begin
            if (byte_valid_i && !byte_ready_o) begin
                err_d = 1'b1;
            end

            if (accept) begin
                fill_ptr_d = fill_ptr_inc;
                rx_total_d = rx_total_inc;
                if (fill_close) begin
                    full_d[fill_bank_q] = 1'b1;
                    len_d[fill_bank_q]  = fill_ptr_inc;
                    fill_bank_d         = ~fill_bank_q;
                    fill_ptr_d          = '0;
                end
            end

            if (take_page) begin
                wr_en_d     = 1'b1;
                page_cnt_d  = page_cnt_q + PAGE_CNT_W'(1);
                drain_ptr_d = '0;
            end

            // A released bank is always full and a closing bank never is, so the
            // two updates of full_d can never target the same bank.
            if (consume) begin
                drained_d   = drained_inc;
                drain_ptr_d = drain_ptr_inc;
                if (last_byte) begin
                    done_d               = 1'b1;
                    full_d[drain_bank_q] = 1'b0;
                    drain_bank_d         = ~drain_bank_q;
                    drain_ptr_d          = '0;
                end
            end
        end
    end

    always_comb begin
        byte_ready_o    = session_q && !full_q[fill_bank_q] && (rx_total_q < size_q);
        ram_re          = 1'b0;
        ram_raddr       = {drain_bank_q, {PAGE_AW{1'b0}}};
        if ((state_q == D_IDLE) && full_q[drain_bank_q] && !prog_start_i) begin
            ram_re = 1'b1;
        end
        if (consume && !last_byte) begin
            ram_re    = 1'b1;
            ram_raddr = {drain_bank_q, drain_ptr_inc[PAGE_AW-1:0]};
        end
        // The RAM read register doubles as the output byte register.
        flash_wr_data_o = (state_q inside {D_LOAD, D_OFFER, D_STREAM}) ? ram_rdata : 8'h00;
        flash_wr_en_o   = wr_en_q;
        flash_wr_done_o = done_q;
        page_cnt_o      = page_cnt_q;
        prog_done_o     = (state_q == D_DONE);
        overflow_err_o  = err_q;
    end

endmodule

// File: tb/tb_flash_page_buffer.sv
// Directed bench for flash_page_buffer: single page, multi-page session,
// back-pressure stall, oversize stream, mid-page abort and zero-size session.
module tb_flash_page_buffer;
    import flash_upd_pkg::*;

    logic                  sys_clk;
    logic                  sys_rst_n;
    logic                  prog_start_i;
    logic [SIZE_W-1:0]     prog_size_i;
    logic                  byte_valid_i;
    logic [7:0]            byte_data_i;
    logic                  byte_ready_o;
    logic                  flash_wr_ready_i;
    logic                  flash_wr_en_o;
    logic [7:0]            flash_wr_data_o;
    logic                  flash_wr_req_i;
    logic                  flash_wr_done_o;
    logic [PAGE_CNT_W-1:0] page_cnt_o;
    logic                  prog_done_o;
    logic                  overflow_err_o;

    int n_cmp = 0;
    int n_mis = 0;
    int en_count = 0;
    int done_count = 0;
    logic [7:0] last_seen;

    flash_page_buffer dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .prog_start_i     (prog_start_i),
        .prog_size_i      (prog_size_i),
        .byte_valid_i     (byte_valid_i),
        .byte_data_i      (byte_data_i),
        .byte_ready_o     (byte_ready_o),
        .flash_wr_ready_i (flash_wr_ready_i),
        .flash_wr_en_o    (flash_wr_en_o),
        .flash_wr_data_o  (flash_wr_data_o),
        .flash_wr_req_i   (flash_wr_req_i),
        .flash_wr_done_o  (flash_wr_done_o),
        .page_cnt_o       (page_cnt_o),
        .prog_done_o      (prog_done_o),
        .overflow_err_o   (overflow_err_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (flash_wr_en_o)   en_count++;
        if (flash_wr_done_o) done_count++;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Image byte k of a session; mode selects the pattern so pages are distinguishable.
    function automatic logic [7:0] pat(input int k, input int mode);
        case (mode)
            0:       return 8'(k);
            1:       return 8'(k + (k >> 8) * 17);
            default: return 8'(k + 'h40);
        endcase
    endfunction

    task automatic start(input int size, input bit with_strobe);
        prog_size_i  = SIZE_W'(size);
        prog_start_i = 1'b1;
        byte_valid_i = with_strobe;
        byte_data_i  = 8'hEE;
        tick();
        prog_start_i = 1'b0;
        byte_valid_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        tick();
        byte_valid_i = 1'b0;
        tick();
    endtask

    task automatic send_range(input int first_k, input int n, input int mode);
        for (int k = first_k; k < first_k + n; k++) send(pat(k, mode));
    endtask

    // Writer model: offers readiness, waits for the page, then requests
    // stop_after bytes spaced two cycles apart and checks each one.
    task automatic drain_page(input string tag, input int first_k, input int len,
                              input int mode, input int stop_after);
        int bad;
        int waited;
        bad    = 0;
        waited = 0;
        flash_wr_ready_i = 1'b1;
        while (!flash_wr_en_o && waited < 2000) begin
            tick();
            waited++;
        end
        check({tag, "_wr_en"}, 32'(flash_wr_en_o), 32'd1);
        flash_wr_ready_i = 1'b0;
        if (!flash_wr_en_o) return;
        for (int i = 0; i < stop_after; i++) begin
            if (flash_wr_data_o !== pat(first_k + i, mode)) bad++;
            last_seen = flash_wr_data_o;
            flash_wr_req_i = 1'b1;
            tick();
            flash_wr_req_i = 1'b0;
            if (i == 0) check({tag, "_en_pulse"}, 32'(flash_wr_en_o), 32'd0);
            if (i == len - 1) check({tag, "_done"}, 32'(flash_wr_done_o), 32'd1);
            else if (flash_wr_done_o) bad++;
            tick();
        end
        check({tag, "_data"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int en0;
        int done0;
        sys_rst_n        = 1'b0;
        prog_start_i     = 1'b0;
        prog_size_i      = '0;
        byte_valid_i     = 1'b0;
        byte_data_i      = 8'h00;
        flash_wr_ready_i = 1'b0;
        flash_wr_req_i   = 1'b0;
        tick();
        tick();
        check("rst_outputs", {byte_ready_o, flash_wr_en_o, flash_wr_done_o, prog_done_o,
                              overflow_err_o, flash_wr_data_o}, 32'd0);
        check("rst_page_cnt", 32'(page_cnt_o), 32'd0);
        sys_rst_n = 1'b1;
        tick();

        // Strobe before any session: not ready, so it is dropped and flagged.
        send(8'h11);
        check("pre_session_err", 32'(overflow_err_o), 32'd1);

        // One full page, writer always ready.
        flash_wr_ready_i = 1'b1;
        en0 = en_count;
        start(256, 1'b0);
        check("t1_start_clears", {byte_ready_o, overflow_err_o, prog_done_o}, 32'b100);
        send_range(0, 256, 0);
        drain_page("t1_p0", 0, 256, 0, 256);
        check("t1_page_cnt", 32'(page_cnt_o), 32'd1);
        check("t1_prog_done", 32'(prog_done_o), 32'd1);
        check("t1_en_pulses", 32'(en_count - en0), 32'd1);

        // 600-byte session: pages of 256, 256 and 88 bytes.
        en0 = en_count;
        start(600, 1'b0);
        send_range(0, 256, 0);
        drain_page("t2_p0", 0, 256, 0, 256);
        check("t2_not_done_mid", 32'(prog_done_o), 32'd0);
        send_range(256, 344, 0);
        drain_page("t2_p1", 256, 256, 0, 256);
        drain_page("t2_p2", 512, 88, 0, 88);
        check("t2_last_byte", 32'(last_seen), 32'h57);
        check("t2_page_cnt", 32'(page_cnt_o), 32'd3);
        check("t2_prog_done", 32'(prog_done_o), 32'd1);
        check("t2_en_pulses", 32'(en_count - en0), 32'd3);

        // Writer stalled: both banks fill, the 513th byte is dropped.
        start(600, 1'b0);
        send_range(0, 512, 1);
        check("t3_ready_low", 32'(byte_ready_o), 32'd0);
        check("t3_no_err_yet", 32'(overflow_err_o), 32'd0);
        send(8'hC3);
        check("t3_overflow", 32'(overflow_err_o), 32'd1);
        drain_page("t3_p0", 0, 256, 1, 256);
        drain_page("t3_p1", 256, 256, 1, 256);
        check("t3_page_cnt", 32'(page_cnt_o), 32'd2);
        check("t3_ready_back", 32'(byte_ready_o), 32'd1);
        check("t3_not_done", 32'(prog_done_o), 32'd0);

        // 300 bytes into a 256-byte session.
        en0 = en_count;
        start(256, 1'b0);
        send_range(0, 256, 0);
        check("t4_err_at_256", 32'(overflow_err_o), 32'd0);
        check("t4_ready_at_256", 32'(byte_ready_o), 32'd0);
        send(pat(256, 0));
        check("t4_err_at_257", 32'(overflow_err_o), 32'd1);
        send_range(257, 43, 0);
        drain_page("t4_p0", 0, 256, 0, 256);
        check("t4_page_cnt", 32'(page_cnt_o), 32'd1);
        check("t4_prog_done", 32'(prog_done_o), 32'd1);
        check("t4_en_pulses", 32'(en_count - en0), 32'd1);

        // Abort after 100 requests, restart with a 10-byte session; the strobe
        // coincident with the restart must be discarded silently.
        start(600, 1'b0);
        send_range(0, 256, 0);
        drain_page("t5_abort", 0, 256, 0, 100);
        start(10, 1'b1);
        check("t5_page_cnt_clr", 32'(page_cnt_o), 32'd0);
        check("t5_outputs_clr", {flash_wr_en_o, flash_wr_done_o, prog_done_o,
                                 overflow_err_o, flash_wr_data_o}, 32'd0);
        check("t5_ready", 32'(byte_ready_o), 32'd1);
        send_range(0, 10, 2);
        drain_page("t5_p0", 0, 10, 2, 10);
        check("t5_page_cnt", 32'(page_cnt_o), 32'd1);
        check("t5_prog_done", 32'(prog_done_o), 32'd1);
        done0 = done_count;
        flash_wr_req_i = 1'b1;
        tick();
        flash_wr_req_i = 1'b0;
        tick();
        check("t5_extra_req_done", 32'(done_count - done0), 32'd0);
        check("t5_extra_req_state", {prog_done_o, flash_wr_data_o}, 32'h100);

        // Zero-size session.
        en0 = en_count;
        start(0, 1'b0);
        check("t6_prog_done", 32'(prog_done_o), 32'd1);
        check("t6_ready", 32'(byte_ready_o), 32'd0);
        flash_wr_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        flash_wr_ready_i = 1'b0;
        check("t6_no_en", 32'(en_count - en0), 32'd0);
        check("t6_page_cnt", 32'(page_cnt_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/flash_page_buffer.md
Name: flash_page_buffer

Overview:
Ping-pong page buffer between uart_decoder (byte producer) and update_flash (page-program consumer). Collects the UART byte stream into 256-byte pages. Offers each full page, or the final partial page, to the flash writer. Serves bytes one per flash_wr_req pulse, so UART reception continues while the previous page programs.

Parameters:
PAGE_BYTES, 256, bytes per flash page program; power of two.
PAGE_AW, 8, log2(PAGE_BYTES).
SIZE_W, 24, width of the program-size and byte counters.

Ports:
sys_clk  in  1  system clock, 100 MHz
sys_rst_n  in  1  asynchronous active-low reset
prog_start_i  in  1  pulse; latches prog_size_i, clears buffer, counters and errors
prog_size_i  in  SIZE_W  total image bytes for this session
byte_valid_i  in  1  one-cycle strobe, byte_data_i valid
byte_data_i  in  8  received image byte
byte_ready_o  out  1  fill bank has space; producer strobes only while high
flash_wr_ready_i  in  1  flash writer idle and able to accept a page
flash_wr_en_o  out  1  one-cycle pulse: page available, first byte on flash_wr_data_o
flash_wr_data_o  out  8  current byte of the page being drained
flash_wr_req_i  in  1  one-cycle pulse: writer consumed flash_wr_data_o
flash_wr_done_o  out  1  one-cycle pulse after the last byte of a page is consumed
page_cnt_o  out  SIZE_W-PAGE_AW+1  pages handed over this session
prog_done_o  out  1  level; all prog_size bytes drained
overflow_err_o  out  1  sticky; byte dropped (strobe while not ready, or beyond prog_size)

Behaviour:
- Reset: all outputs 0. Bank flags empty, pointers 0, FSMs idle.
- Storage: 2 x PAGE_BYTES x 8, inferred RAM, one write port and one synchronous read port.
- Per-bank state: full flag, length (1..PAGE_BYTES, held as PAGE_AW+1 bits).
- Fill side:
  - fill_bank, fill_ptr, rx_total.
  - byte_ready_o = !full[fill_bank] && rx_total < size && session active.
  - Accepted byte: write RAM, increment fill_ptr and rx_total.
  - Bank closes on the same edge as the byte that makes fill_ptr reach PAGE_BYTES or rx_total reach size. On close: full=1, length recorded, fill_bank toggles, fill_ptr=0.
  - Strobe while byte_ready_o=0: byte discarded, overflow_err_o=1.
- Drain FSM states D_IDLE, D_LOAD, D_OFFER, D_STREAM, D_DONE:
  - D_IDLE -> D_LOAD when full[drain_bank]. Issue RAM read at addr 0.
  - D_LOAD -> D_OFFER after 1 cycle; data registered to flash_wr_data_o.
  - D_OFFER: wait for flash_wr_ready_i=1. Then pulse flash_wr_en_o, increment page_cnt_o, go to D_STREAM.
  - D_STREAM: each flash_wr_req_i advances drain_ptr. The next byte appears on flash_wr_data_o exactly 1 cycle after the req. The writer must not re-request sooner than 2 cycles.
  - Req consuming byte length-1: pulse flash_wr_done_o the next cycle, clear full[drain_bank], toggle drain_bank. Go to D_DONE if total drained == size, else D_IDLE.
  - Extra flash_wr_req_i outside D_STREAM: ignored.
  - D_DONE: prog_done_o=1 until next prog_start_i.
- Same-cycle bank release (drain) and bank close (fill) on different banks are independent; both take effect.
- prog_start_i at any time, including mid-page: abort, flags/pointers/counters/errors cleared next cycle, flash outputs deasserted, FSM to D_IDLE.
- prog_size_i = 0: prog_done_o=1 the cycle after prog_start_i. byte_ready_o stays 0.
- Byte strobe in the same cycle as prog_start_i: discarded, no error.
- Throughput: UART at 115200 baud is far slower than drain, so the fill side stalls only while both banks are full.

Decomposition:
- Shared package flash_upd_pkg: PAGE_BYTES, PAGE_AW, SIZE_W, drain-state encoding.
- One sub-module, page_dpram: simple dual-port RAM, 2*PAGE_BYTES deep, registered read.
- FSMs and counters stay in flash_page_buffer.

Test Plan:
- prog_size=256, send bytes 0x00..0xFF, writer always ready -> one flash_wr_en_o pulse, 256 reqs return 0x00..0xFF in order, one flash_wr_done_o, page_cnt=1, prog_done_o=1.
- prog_size=600, incrementing pattern -> pages of 256, 256, 88 bytes, page_cnt=3, final page ends with byte 0x57 (599 mod 256), prog_done_o=1.
- Writer holds flash_wr_ready_i=0 while 512 bytes arrive -> byte_ready_o drops after byte 512. Byte 513 strobe sets overflow_err_o and is dropped. After the ready release, both pages drain intact.
- Send 300 bytes with prog_size=256 -> bytes 257..300 each set overflow_err_o, a single page drains, prog_done_o=1.
- prog_start_i asserted after 100 reqs of a page -> outputs cleared next cycle, page_cnt=0. New session prog_size=10 completes correctly with a 10-byte page.
- prog_size=0 -> prog_done_o=1 one cycle after start, no flash_wr_en_o, byte_ready_o=0.
